// File: rtl/pattern_valid_generator.sv
// ---------------------------------------------------------------------------
// pattern_valid_generator
//
// Transmit-side valid-lane pattern generator for the mainband Tx path.
// Each clock it drives one 32-bit valid-lane word (bit 0 goes out first).
// The word is either the VALTRAIN pattern 32'hF0F0F0F0 (four 11110000
// iterations) or all zeros.
//
// Training bursts
//   A burst is started by i_start and runs for ITER_LONG/4 or ITER_SHORT/4
//   pattern words. It is followed by GAP_CYCLES all-zero words. At the end
//   of the gap, i_repeat either chains another burst or returns to IDLE with
//   a one-cycle o_done pulse.
//
// Functional framing
//   In IDLE, i_data_valid frames the same cycle's data with one pattern word
//   on the next clock.
//
// Ports
//   i_clk               system clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_enable_generator  block enable; low forces IDLE and clears counters
//   i_enable_128        mode bit 0: ITER_LONG burst
//   i_enable_cons       mode bit 1: ITER_SHORT burst
//   i_start             single-cycle burst request, honoured in IDLE only
//   i_repeat            sampled on the last gap word; 1 = chain next burst
//   i_data_valid        functional-mode framing request, honoured in IDLE
//   TVLD_L              registered valid-lane word
//   o_busy              high while a burst (pattern or gap) is in progress
//   o_done              one-cycle pulse when a burst ends without repeat
//   o_mode_err          one-cycle pulse when i_start sees mode 00 or 11
//   o_iter_sent         iterations sent in the current or last burst
//
// Request semantics: i_start, i_repeat and i_data_valid are plain level
// samples taken on the rising edge. There is no back-pressure. A request
// that arrives in a state that ignores it is dropped, not queued.
// ---------------------------------------------------------------------------
module pattern_valid_generator #(
    parameter int ITER_LONG  = 128,
    parameter int ITER_SHORT = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable_generator,
    input  logic        i_enable_128,
    input  logic        i_enable_cons,
    input  logic        i_start,
    input  logic        i_repeat,
    input  logic        i_data_valid,
    output logic [31:0] TVLD_L,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_mode_err,
    output logic [9:0]  o_iter_sent
);

    localparam logic [31:0] PATTERN_WORD = 32'hF0F0F0F0;
    localparam logic [7:0]  LONG_WORDS   = 8'(ITER_LONG / 4);
    localparam logic [7:0]  SHORT_WORDS  = 8'(ITER_SHORT / 4);
    localparam logic [3:0]  GAP_LAST     = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PATTERN = 2'd1,
        S_GAP     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;       // pattern words already on the lane
    logic [3:0]  gap_cnt_q, gap_cnt_d;         // gap words already on the lane
    logic [7:0]  burst_words_q, burst_words_d; // burst length latched at start
    logic [31:0] tvld_q, tvld_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mode_err_q, mode_err_d;
    logic [9:0]  iter_q, iter_d;

    logic [1:0]  mode;
    logic        mode_legal;

    assign mode       = {i_enable_cons, i_enable_128};
    assign mode_legal = (mode == 2'b01) || (mode == 2'b10);

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        burst_words_d = burst_words_q;
        tvld_d        = '0;
        done_d        = 1'b0;
        mode_err_d    = 1'b0;
        iter_d        = iter_q;

        if (!i_enable_generator) begin
            // Abort: counters clear, but o_iter_sent keeps the truncated count.
            state_d    = S_IDLE;
            word_cnt_d = '0;
            gap_cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        // i_start takes priority over i_data_valid.
                        if (mode_legal) begin
                            state_d       = S_PATTERN;
                            burst_words_d = (mode == 2'b01) ? LONG_WORDS : SHORT_WORDS;
                            word_cnt_d    = 8'd1;
                            gap_cnt_d     = '0;
                            iter_d        = 10'd4;
                            tvld_d        = PATTERN_WORD;
                        end else begin
                            mode_err_d = 1'b1;
                        end
                    end else if (i_data_valid) begin
                        tvld_d = PATTERN_WORD;
                    end
                end

                S_PATTERN: begin
                    if (word_cnt_q == burst_words_q) begin
                        // The last pattern word is on the lane; the first gap word goes out now.
                        state_d    = S_GAP;
                        word_cnt_d = '0;
                        gap_cnt_d  = 4'd1;
                    end else begin
                        tvld_d     = PATTERN_WORD;
                        word_cnt_d = word_cnt_q + 8'd1;
                        iter_d     = iter_q + 10'd4;
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        if (i_repeat) begin
                            state_d    = S_PATTERN;
                            word_cnt_d = 8'd1;
                            iter_d     = 10'd4;
                            tvld_d     = PATTERN_WORD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // o_busy is registered from the next state so that it lines up with TVLD_L.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            burst_words_q <= '0;
            tvld_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mode_err_q    <= 1'b0;
            iter_q        <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            burst_words_q <= burst_words_d;
            tvld_q        <= tvld_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mode_err_q    <= mode_err_d;
            iter_q        <= iter_d;
        end
    end

    assign TVLD_L      = tvld_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_mode_err  = mode_err_q;
    assign o_iter_sent = iter_q;

endmodule

// File: tb/tb_pattern_valid_generator.sv
module tb_pattern_valid_generator;

    localparam int ITER_LONG  = 128;
    localparam int ITER_SHORT = 16;
    localparam int GAP_CYCLES = 2;
    localparam logic [31:0] PAT = 32'hF0F0F0F0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en, en128, encons, start, rep, dv;
    logic [31:0] tvld;
    logic        busy, done, merr;
    logic [9:0]  iter;

    int checks = 0;
    int failures = 0;

    pattern_valid_generator #(
        .ITER_LONG (ITER_LONG),
        .ITER_SHORT(ITER_SHORT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_enable_generator(en),
        .i_enable_128      (en128),
        .i_enable_cons     (encons),
        .i_start           (start),
        .i_repeat          (rep),
        .i_data_valid      (dv),
        .TVLD_L            (tvld),
        .o_busy            (busy),
        .o_done            (done),
        .o_mode_err        (merr),
        .o_iter_sent       (iter)
    );

    // ---------------- reference model ----------------
    // A burst is modelled as a queue of the words it still has to put on the
    // lane. The model is busy while a burst is in progress. When the queue is
    // empty, the last gap word is showing and the next edge decides whether
    // the burst repeats or finishes.
    logic [31:0] m_q[$];
    logic [31:0] m_tvld;
    logic        m_busy, m_done, m_err;
    int          m_iter;
    int          m_words;

    task automatic model_reset();
        m_q.delete();
        m_tvld = '0; m_busy = 0; m_done = 0; m_err = 0; m_iter = 0;
    endtask

    task automatic model_load();
        m_q.delete();
        for (int i = 0; i < m_words; i++) m_q.push_back(PAT);
        for (int i = 0; i < GAP_CYCLES; i++) m_q.push_back(32'h0);
        m_iter = 0;
        m_busy = 1;
    endtask

    task automatic model_pop();
        m_tvld = m_q.pop_front();
        if (m_tvld == PAT) m_iter += 4;
    endtask

    task automatic model_edge();
        m_done = 0; m_err = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            m_q.delete(); m_busy = 0; m_tvld = '0;
        end else if (m_busy) begin
            if (m_q.size() == 0) begin
                if (rep) begin
                    model_load(); model_pop();
                end else begin
                    m_busy = 0; m_tvld = '0; m_done = 1;
                end
            end else begin
                model_pop();
            end
        end else if (start) begin
            if ({encons, en128} == 2'b01 || {encons, en128} == 2'b10) begin
                m_words = ({encons, en128} == 2'b01) ? ITER_LONG / 4 : ITER_SHORT / 4;
                model_load(); model_pop();
            end else begin
                m_err = 1; m_tvld = '0;
            end
        end else begin
            m_tvld = dv ? PAT : 32'h0;
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: the model follows the edge and all outputs are compared 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {19'd0, tvld, busy, done, merr, iter},
            {19'd0, m_tvld, m_busy, m_done, m_err, 10'(m_iter)});
    endtask

    task automatic set_in(input logic e, input logic [1:0] mode, input logic s,
                          input logic r, input logic d);
        en = e; {encons, en128} = mode; start = s; rep = r; dv = d;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        start;
        logic        rep;
        logic        dv;
        logic [31:0] tvld;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Starts from IDLE: illegal modes, functional framing, then a start
        // that collides with i_data_valid and a CONSEC burst that ignores dv.
        vecs[0]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, PAT,   1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, PAT,   1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, PAT,   1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b1, PAT,   1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, PAT,   1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, PAT,   1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, PAT,   1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    end

    // ---------------- test sequence ----------------
    initial begin
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        chk("reset_tvld", 64'(tvld), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_iter", 64'(iter), 64'h0);
        chk("reset_flags", 64'({done, merr}), 64'h0);
        repeat (2) cycle();
        #2 rst_n = 1'b1;

        // Idle with a legal mode and no start.
        set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_quiet", 64'({tvld, busy, done}), 64'h0);
        end

        // ITER_128 burst: 32 pattern words, 2 gap words, then o_done.
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("long_first_word", 64'(tvld), 64'(PAT));
        chk("long_first_iter", 64'(iter), 64'd4);
        for (int i = 1; i < 32; i++) begin
            cycle();
            chk("long_pattern", 64'({tvld, busy}), 64'({PAT, 1'b1}));
        end
        chk("long_iter_end", 64'(iter), 64'd128);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("long_gap", 64'({tvld, busy, done}), 64'({32'h0, 1'b1, 1'b0}));
        end
        cycle();
        chk("long_done", 64'({busy, done}), 64'({1'b0, 1'b1}));
        chk("long_iter_final", 64'(iter), 64'd128);
        cycle();
        chk("long_done_pulse", 64'(done), 64'h0);

        // CONSEC_16 with repeat: periods of 4 pattern words and 2 gap words.
        // The repeat is dropped during the fourth period.
        set_in(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        cycle();
        start = 1'b0;
        for (int t = 1; t < 24; t++) begin
            rep = (t <= 18);
            cycle();
            chk("cons_word", 64'(tvld), 64'((t % 6 < 4) ? PAT : 32'h0));
            chk("cons_no_done", 64'({busy, done}), 64'({1'b1, 1'b0}));
        end
        cycle();
        chk("cons_done", 64'({tvld, busy, done}), 64'({32'h0, 1'b0, 1'b1}));
        chk("cons_iter", 64'(iter), 64'd16);

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].en, vecs[i].mode, vecs[i].start, vecs[i].rep, vecs[i].dv);
            cycle();
            chk($sformatf("vec%0d", i), 64'({tvld, busy, done, merr}),
                64'({vecs[i].tvld, vecs[i].busy, vecs[i].done, vecs[i].err}));
        end

        // Abort by enable after word 10 of an ITER_128 burst.
        set_in(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        cycle();
        start = 1'b0;
        repeat (9) cycle();
        chk("abort_iter_before", 64'(iter), 64'd40);
        en = 1'b0;
        cycle();
        chk("abort_en", 64'({tvld, busy, done}), 64'h0);
        chk("abort_en_iter", 64'(iter), 64'd40);
        en = 1'b1;
        cycle();
        chk("abort_en_after", 64'({tvld, busy, done}), 64'h0);

        // Abort by asynchronous reset mid-burst.
        set_in(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rst", 64'({tvld, busy, done, merr}), 64'h0);
        chk("abort_rst_iter", 64'(iter), 64'h0);
        model_reset();
        cycle();
        rst_n = 1'b1;

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 59) != 0), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_valid_generator.md
Name: pattern_valid_generator

Overview:
- Transmit-side counterpart of the mainband valid-lane pattern detector.
- Drives the 32-bit-per-clock valid-lane word TVLD_L, carrying the VALTRAIN pattern. The 8-bit unit is 11110000; one 32-bit word is four iterations.
- Covers two cases: training bursts, either 128 iterations (ITER_128) or 16 consecutive iterations (CONSEC_16), each followed by a low gap; and functional-mode valid framing alongside transmitted data.
- Sits in the MB Tx path, controlled by the link training state machine.

Parameters:
- ITER_LONG, 128, iterations per ITER_128 burst; must be a multiple of 4, 4..1020.
- ITER_SHORT, 16, iterations per CONSEC_16 burst; must be a multiple of 4, 4..1020.
- GAP_CYCLES, 2, clocks of all-zero TVLD_L after each burst; 1..15.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable_generator  in  1  block enable; low forces IDLE.
- i_enable_128  in  1  selects ITER_128 burst length.
- i_enable_cons  in  1  selects CONSEC_16 burst length.
- i_start  in  1  single-cycle request to begin a training burst.
- i_repeat  in  1  sampled at end of gap; high means start the next burst back-to-back.
- i_data_valid  in  1  functional mode: frame this cycle's data with a valid pattern.
- TVLD_L  out  32  valid-lane word, bit 0 transmitted first; 32'hF0F0F0F0 when active, 0 otherwise.
- o_busy  out  1  high in PATTERN or GAP.
- o_done  out  1  one-cycle pulse when a burst completes without repeat.
- o_mode_err  out  1  one-cycle pulse when i_start is accepted with an illegal mode.
- o_iter_sent  out  10  iterations emitted in the current or last burst.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. While reset is asserted:
  - TVLD_L=0, o_busy=0, o_done=0, o_mode_err=0, o_iter_sent=0;
  - state=IDLE, counters cleared.
  - Reset mid-burst truncates the burst immediately.
- Mode: mode={i_enable_cons,i_enable_128}.
  - 01 → burst length ITER_LONG/4 words; 10 → ITER_SHORT/4 words; 00 and 11 are illegal.
  - Mode is latched at start and ignored while busy.
- All outputs are registered. TVLD_L changes only on the rising edge of i_clk.
- IDLE state:
  - Start accept: i_enable_generator=1, i_start=1, legal mode. On that edge: state→PATTERN, TVLD_L←F0F0F0F0, word counter←1, o_iter_sent←4. The first pattern word is present in the cycle after the accepting edge, i.e. latency 1 clock.
  - Illegal mode: i_start=1 with mode 00/11 → o_mode_err pulses one cycle, stay IDLE.
  - Functional framing: no start, i_data_valid=1 → TVLD_L←F0F0F0F0; otherwise TVLD_L←0.
  - i_start and i_data_valid together: i_start wins.
- PATTERN state:
  - Each edge: TVLD_L←F0F0F0F0, counter+1, o_iter_sent+4.
  - Exactly N=ITER/4 consecutive pattern words are emitted (32 for ITER_LONG=128, 4 for ITER_SHORT=16).
  - After word N: state→GAP, TVLD_L←0.
  - i_start and i_data_valid are ignored.
- GAP state:
  - Emits exactly GAP_CYCLES all-zero words.
  - At the edge ending the last gap word:
    - if i_repeat=1: state→PATTERN with the same latched mode; TVLD_L←pattern; o_iter_sent←4; no o_done.
    - else: state→IDLE, o_done←1 for one cycle, o_iter_sent holds its final value.
- o_busy=1 exactly while state is PATTERN or GAP.
- Disable: i_enable_generator=0 in any state → next edge state→IDLE, TVLD_L←0, counters cleared, o_busy=0, no o_done. o_iter_sent holds the truncated count.
- Widths: word counter 8 bits, gap counter 4 bits, o_iter_sent 10 bits. No wrap is possible within the legal parameter range.

Test Plan:
- Reset/idle: reset, then enable=1, mode=01, no start → TVLD_L=0, o_busy=0, o_done=0.
- ITER_128 burst: mode=01, i_start pulse at edge N →
  - TVLD_L=F0F0F0F0 for 32 cycles after edge N;
  - then 2 zero words; o_done pulse in the following cycle;
  - o_iter_sent=128; o_busy high for 34 cycles.
- CONSEC_16 with repeat: mode=10, i_repeat=1, start → repeating cycles of 4 pattern words + 2 zero words, no o_done. Drop i_repeat → o_done after the current gap, o_iter_sent=16.
- Illegal mode: mode=11, start → o_mode_err one-cycle pulse, TVLD_L stays 0, o_busy=0.
- Functional framing: IDLE, i_data_valid pattern 1,0,1,1 → TVLD_L one cycle later is F0F0F0F0, 0, F0F0F0F0, F0F0F0F0. i_start together with i_data_valid → a burst starts.
- Abort: mid ITER_128 burst after word 10, drop i_enable_generator → TVLD_L=0 next cycle, o_busy=0, no o_done, o_iter_sent=40. Repeat with i_rst_n asserted mid-burst → immediate clear of all outputs.
- Loopback: connect to the receive-side detector with mode 10 → detection_result=1 after the burst.
